// File: rtl/seg7_refresh_ctrl.sv
// seg7_refresh_ctrl: shadow registers for a 7-segment display. Each write,
// periodic refresh tick or flash-phase change schedules one transfer to the
// downstream serializer. Requests that arrive while a transfer is in flight
// coalesce into a single follow-up transfer.
module seg7_refresh_ctrl #(
  parameter int unsigned REFRESH_CYC = 50000,
  parameter int unsigned FLASH_CYC   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        ser_idle,
  output logic        start,
  output logic [31:0] hexs,
  output logic [7:0]  point,
  output logic [7:0]  les,
  output logic        sw0,
  output logic        flash,
  output logic        busy
);

  localparam int RW = $clog2(REFRESH_CYC);
  localparam int FW = $clog2(FLASH_CYC);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYC - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYC - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    wb_cnt_q, wb_cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_reg_q, flash_reg_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    pnt_q, pnt_d;
  logic [7:0]    les_reg_q, les_reg_d;
  logic          mode_q, mode_d;
  logic          dirty_q, dirty_d;
  logic          pending_q, pending_d;
  logic [31:0]   hexs_q, hexs_d;
  logic [7:0]    point_q, point_d;
  logic [7:0]    les_q, les_d;
  logic          sw0_q, sw0_d;
  logic          flash_q, flash_d;

  logic ref_wrap;
  logic flash_wrap;
  logic in_load;

  assign ref_wrap   = (ref_cnt_q == REF_LAST);
  assign flash_wrap = (flash_cnt_q == FLASH_LAST);
  assign in_load    = (state_q == S_LOAD);

  // Shadow registers, free-running counters and the dirty/pending request flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    data_d      = data_q;
    pnt_d       = pnt_q;
    les_reg_d   = les_reg_q;
    mode_d      = mode_q;
    ref_cnt_d   = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    flash_cnt_d = flash_wrap ? '0 : flash_cnt_q + 1'b1;
    flash_reg_d = flash_wrap ? ~flash_reg_q : flash_reg_q;
    dirty_d     = dirty_q;
    pending_d   = pending_q;

    if (wr_en) begin
      unique case (wr_addr)
        2'd0: data_d = wr_data;
        2'd1: begin
          pnt_d     = wr_data[7:0];
          les_reg_d = wr_data[15:8];
        end
        2'd2: mode_d = wr_data[0];
        default: ;  // address 3 only forces a refresh
      endcase
    end

    // Clear first so a set event in the same cycle takes priority.
    if (in_load) begin
      dirty_d   = 1'b0;
      pending_d = 1'b0;
    end
    if (wr_en) dirty_d = 1'b1;
    if (ref_wrap || flash_wrap) pending_d = 1'b1;
  end

  // Transfer FSM and the output registers it loads.
  always_comb begin
    state_d  = state_q;
    wb_cnt_d = wb_cnt_q;
    hexs_d   = hexs_q;
    point_d  = point_q;
    les_d    = les_q;
    sw0_d    = sw0_q;
    flash_d  = flash_q;

    unique case (state_q)
      S_IDLE: begin
        if ((dirty_q || pending_q) && ser_idle) state_d = S_LOAD;
      end
      S_LOAD: begin
        hexs_d  = data_q;
        point_d = pnt_q;
        les_d   = les_reg_q;
        sw0_d   = mode_q;
        flash_d = flash_reg_q;
        state_d = S_START;
      end
      S_START: begin
        wb_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Give up after four idle cycles in case the start pulse was missed.
        if (!ser_idle) begin
          state_d = S_WAIT_IDLE;
        end else if (wb_cnt_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          wb_cnt_d = wb_cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (ser_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset presents blank hex-mode data and schedules a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= S_IDLE;
      wb_cnt_q    <= '0;
      ref_cnt_q   <= '0;
      flash_cnt_q <= '0;
      flash_reg_q <= 1'b0;
      data_q      <= '0;
      pnt_q       <= '0;
      les_reg_q   <= '0;
      mode_q      <= 1'b1;
      dirty_q     <= 1'b1;
      pending_q   <= 1'b0;
      hexs_q      <= '0;
      point_q     <= '0;
      les_q       <= '0;
      sw0_q       <= 1'b1;
      flash_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_cnt_q    <= wb_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_reg_q <= flash_reg_d;
      data_q      <= data_d;
      pnt_q       <= pnt_d;
      les_reg_q   <= les_reg_d;
      mode_q      <= mode_d;
      dirty_q     <= dirty_d;
      pending_q   <= pending_d;
      hexs_q      <= hexs_d;
      point_q     <= point_d;
      les_q       <= les_d;
      sw0_q       <= sw0_d;
      flash_q     <= flash_d;
    end
  end

  assign start = (state_q == S_START);
  assign busy  = (state_q != S_IDLE);
  assign hexs  = hexs_q;
  assign point = point_q;
  assign les   = les_q;
  assign sw0   = sw0_q;
  assign flash = flash_q;

endmodule

// File: tb/tb_seg7_refresh_ctrl.sv
// Bench for seg7_refresh_ctrl. Instance a (slow timers) is driven by directed
// write/serializer sequences and checked through an expected-transfer queue
// popped on every start pulse. Instance b (fast timers) runs free against a
// responsive serializer to observe the refresh and flash cadence.
module tb_seg7_refresh_ctrl;

  typedef struct packed {
    logic [31:0] hexs;
    logic [7:0]  point;
    logic [7:0]  les;
    logic        sw0;
    logic        flash;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  exp_t sb[$];

  // ---------------- instance a ----------------
  logic        rst_a = 1'b0;
  logic        a_wr_en = 1'b0;
  logic [1:0]  a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic        a_ser_idle;
  logic        a_start, a_sw0, a_flash, a_busy;
  logic [31:0] a_hexs;
  logic [7:0]  a_point, a_les;

  logic a_auto      = 1'b0;
  logic a_man_idle  = 1'b1;
  logic a_model_idle = 1'b1;
  int   a_low       = 0;
  int   a_low_len   = 3;
  assign a_ser_idle = a_auto ? a_model_idle : a_man_idle;

  seg7_refresh_ctrl #(.REFRESH_CYC(20000), .FLASH_CYC(40000)) dut_a (
    .clk(clk), .rst(rst_a), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .ser_idle(a_ser_idle), .start(a_start),
    .hexs(a_hexs), .point(a_point), .les(a_les), .sw0(a_sw0),
    .flash(a_flash), .busy(a_busy)
  );

  // ---------------- instance b ----------------
  logic        rst_b = 1'b0;
  logic        b_ser_idle = 1'b1;
  logic        b_start, b_sw0, b_flash, b_busy;
  logic [31:0] b_hexs;
  logic [7:0]  b_point, b_les;
  int          b_low = 0;

  seg7_refresh_ctrl #(.REFRESH_CYC(16), .FLASH_CYC(40)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(1'b0), .wr_addr(2'd0),
    .wr_data(32'd0), .ser_idle(b_ser_idle), .start(b_start),
    .hexs(b_hexs), .point(b_point), .les(b_les), .sw0(b_sw0),
    .flash(b_flash), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                      input logic s, input logic f);
    exp_t e;
    e.hexs = h; e.point = p; e.les = l; e.sw0 = s; e.flash = f;
    sb.push_back(e);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_start !== 1'b1 && n < max_cyc);
    check(name, {31'd0, a_start}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hexs"},  a_hexs, 32'd0);
    check({tag, "_point"}, {24'd0, a_point}, 32'd0);
    check({tag, "_les"},   {24'd0, a_les}, 32'd0);
    check({tag, "_sw0"},   {31'd0, a_sw0}, 32'd1);
    check({tag, "_flash"}, {31'd0, a_flash}, 32'd0);
    check({tag, "_start"}, {31'd0, a_start}, 32'd0);
    check({tag, "_busy"},  {31'd0, a_busy}, 32'd0);
  endtask

  // Monitor: every start pulse of instance a must match the oldest expectation.
  always @(negedge clk) begin
    if (a_start === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_start: got start=1 with hexs 0x%08h, expected no transfer at %0t",
                 a_hexs, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hexs",  a_hexs, e.hexs);
        check("sb_point", {24'd0, a_point}, {24'd0, e.point});
        check("sb_les",   {24'd0, a_les}, {24'd0, e.les});
        check("sb_sw0",   {31'd0, a_sw0}, {31'd0, e.sw0});
        check("sb_flash", {31'd0, a_flash}, {31'd0, e.flash});
      end
    end
  end

  // Responsive serializer for instance a (used when a_auto is set).
  always @(negedge clk) begin
    if (a_start === 1'b1) begin
      a_model_idle = 1'b0;
      a_low = a_low_len;
    end else if (a_low > 0) begin
      a_low--;
      if (a_low == 0) a_model_idle = 1'b1;
    end
  end

  // Responsive serializer for instance b: busy for three cycles per transfer.
  always @(negedge clk) begin
    if (b_start === 1'b1) begin
      b_ser_idle = 1'b0;
      b_low = 3;
    end else if (b_low > 0) begin
      b_low--;
      if (b_low == 0) b_ser_idle = 1'b1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      // ------------- instance a: directed sequences -------------
      begin
        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");

        // Release: one transfer of reset values, then lost-start recovery.
        push(32'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        rst_a = 1'b1;
        wait_start(3, "post_reset_start");
        repeat (4) @(negedge clk);
        check("recover_busy_high", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        check("recover_busy_low", {31'd0, a_busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Back-to-back writes coalesce into one transfer, 3 cycles after first write.
        a_auto = 1'b1;
        push(32'h12345678, 8'hF0, 8'hA5, 1'b1, 1'b0);
        do_write(2'd0, 32'h12345678);
        do_write(2'd1, 32'h0000A5F0);
        @(negedge clk);
        check("write_latency_start", {31'd0, a_start}, 32'd1);
        repeat (30) @(negedge clk);
        a_auto = 1'b0;
        a_man_idle = 1'b1;

        // Mode write, then writes during a long transfer.
        push(32'h12345678, 8'hF0, 8'hA5, 1'b0, 1'b0);
        do_write(2'd2, 32'h0000_0000);
        wait_start(10, "mode_write_start");
        @(negedge clk);
        a_man_idle = 1'b0;
        for (int i = 1; i <= 64; i++) begin
          @(negedge clk);
          if (i == 10) begin
            a_wr_en = 1'b1; a_wr_addr = 2'd0; a_wr_data = 32'hDEADBEEF;
          end else if (i == 20) begin
            a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 32'h00003C81;
          end else begin
            a_wr_en = 1'b0;
          end
          if (i == 21) push(32'hDEADBEEF, 8'h81, 8'h3C, 1'b0, 1'b0);
        end
        check("hexs_held_in_transfer", a_hexs, 32'h12345678);
        check("busy_in_transfer", {31'd0, a_busy}, 32'd1);
        a_man_idle = 1'b1;
        wait_start(10, "followup_start");
        repeat (10) @(negedge clk);

        // Force refresh, then reset while waiting for the serializer to go idle.
        push(32'hDEADBEEF, 8'h81, 8'h3C, 1'b0, 1'b0);
        do_write(2'd3, 32'hFFFFFFFF);
        wait_start(10, "force_refresh_start");
        @(negedge clk);
        a_man_idle = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b0;
        #1 check_reset_outputs("rst_mid");
        push(32'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        a_man_idle = 1'b1;
        @(negedge clk);
        rst_a = 1'b1;
        wait_start(5, "post_midreset_start");
        repeat (10) @(negedge clk);
      end

      // ------------- instance b: refresh / flash cadence -------------
      begin
        int starts;
        int last;
        int max_gap;
        starts = 0; last = -1; max_gap = 0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        for (int c = 1; c <= 200; c++) begin
          @(negedge clk);
          if (b_start === 1'b1) begin
            starts++;
            if (last >= 0 && (c - last) > max_gap) max_gap = c - last;
            last = c;
          end
          if (c == 35)  check("b_flash_35",  {31'd0, b_flash}, 32'd0);
          if (c == 60)  check("b_flash_60",  {31'd0, b_flash}, 32'd1);
          if (c == 100) check("b_flash_100", {31'd0, b_flash}, 32'd0);
          if (c == 140) check("b_flash_140", {31'd0, b_flash}, 32'd1);
        end
        check("b_start_count", starts, 32'd15);
        check("b_max_start_gap", max_gap, 32'd16);
      end
    join

    check("sb_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_refresh_ctrl.md
SEG7_REFRESH_CTRL -- requirements
Module: seg7_refresh_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_CYC, default 50000: clock cycles between periodic refresh requests (>=8).
REQ-002 SHALL have parameter FLASH_CYC, default 25000000: clock cycles per flash phase (>=8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port wr_en  input  1  register write strobe, one write per cycle high.
REQ-006 SHALL have port wr_addr  input  2  write target: 0 data, 1 point/LES, 2 mode, 3 force refresh.
REQ-007 SHALL have port wr_data  input  32  write payload.
REQ-008 SHALL have port ser_idle  input  1  high when the downstream serializer is idle.
REQ-009 SHALL have port start  output  1  one-cycle pulse launching a serializer transfer.
REQ-010 SHALL have port hexs  output  32  display data presented to the 7-seg device.
REQ-011 SHALL have port point  output  8  decimal-point enables.
REQ-012 SHALL have port les  output  8  per-digit flash enables.
REQ-013 SHALL have port sw0  output  1  display mode (1 text/hex, 0 graphic map).
REQ-014 SHALL have port flash  output  1  blink phase.
REQ-015 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-016 Write addr 0 SHALL load data_reg <= wr_data; addr 1 SHALL load pnt_reg <= wr_data[7:0], les_reg <= wr_data[15:8]; addr 2 SHALL load mode_reg <= wr_data[0]; addr 3 SHALL change no register.
REQ-017 Every write (any addr) SHALL set the dirty flag at the same edge.
REQ-018 Refresh counter SHALL free-run 0..REFRESH_CYC-1, wrap to 0, and set pending on the edge it wraps.
REQ-019 Flash counter SHALL free-run 0..FLASH_CYC-1; on wrap it SHALL toggle flash_reg and set pending.
REQ-020 FSM states SHALL be IDLE, LOAD, START, WAIT_BUSY, WAIT_IDLE.
REQ-021 IDLE -> LOAD when (dirty or pending) and ser_idle=1; otherwise stay IDLE.
REQ-022 LOAD SHALL copy data_reg, pnt_reg, les_reg, mode_reg, flash_reg to hexs, point, les, sw0, flash and clear dirty and pending; -> START.
REQ-023 A set event (write, wrap) coinciding with the LOAD clear SHALL win: flag remains set.
REQ-024 START SHALL drive start=1 for exactly that cycle; -> WAIT_BUSY.
REQ-025 WAIT_BUSY -> WAIT_IDLE when ser_idle=0; if ser_idle stays 1 for 4 cycles in WAIT_BUSY -> IDLE (lost-start recovery).
REQ-026 WAIT_IDLE -> IDLE when ser_idle=1.
REQ-027 Latency: request set with ser_idle=1 in IDLE SHALL give start=1 exactly 2 cycles after the FSM samples the request (IDLE->LOAD->START).
REQ-028 Outputs hexs/point/les/sw0/flash SHALL change only in LOAD; stable throughout a transfer.
REQ-029 start SHALL be 0 in all states except START.
REQ-030 Writes during a transfer SHALL update shadow registers and set dirty, causing one further transfer after return to IDLE; multiple writes SHALL coalesce into one transfer.

Reset
REQ-031 rst=0 SHALL immediately force: FSM IDLE, start 0, busy 0, hexs 0, point 0, les 0, sw0 1, flash 0, all shadow registers as outputs, counters 0, dirty 1, pending 0.
REQ-032 Reset mid-transfer SHALL abort without emitting start; after release one transfer of reset values SHALL follow (dirty=1).

Verification
REQ-033 Release reset, ser_idle=1 -> one start pulse within 3 cycles, hexs=0, sw0=1; no second pulse until a request.
REQ-034 Write addr0 0x12345678, addr1 0x0000A5F0 while idle -> one start (coalesced if back-to-back), hexs=0x12345678, point=0xF0, les=0xA5.
REQ-035 ser_idle drops 1 cycle after start, held low 64 cycles; write addr0 0xDEADBEEF at cycle 10 -> hexs unchanged until ser_idle=1, then second start, hexs=0xDEADBEEF.
REQ-036 REFRESH_CYC=16, FLASH_CYC=40, no writes, serializer responsive -> start every ~16 cycles; flash toggles every 40 cycles, visible on flash after next LOAD.
REQ-037 ser_idle held 1 permanently after start -> FSM returns to IDLE after 4 cycles in WAIT_BUSY; busy falls.
REQ-038 Assert rst in WAIT_IDLE -> all outputs at reset values same cycle; post-release transfer occurs.
